// File: rtl/conv_filter_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv_filter_engine
// Description : 36-term signed int8 dot-product engine fed by the weight
//               loader's packed filter buses. Conv1 applies one filter per
//               window; conv2 sweeps eight filters per window by driving
//               Filtr_2_count back to the loader. Three-stage pipeline
//               (products, row sums, final sum) with a one-cycle result strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_filter_engine #(
    parameter int PSUM_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     layer_sel,
    input  logic [CNT_W-1:0]         i_num_windows,
    input  logic                     weights_load_finish,
    input  logic [95:0]              Filtr_1_2,
    input  logic [95:0]              Filtr_1_1,
    input  logic [95:0]              Filtr_1_0,
    input  logic [95:0]              Filtr_2_2,
    input  logic [95:0]              Filtr_2_1,
    input  logic [95:0]              Filtr_2_0,
    output logic [2:0]               Filtr_2_count,
    input  logic [95:0]              i_act_2,
    input  logic [95:0]              i_act_1,
    input  logic [95:0]              i_act_0,
    input  logic                     i_act_valid,
    output logic                     o_act_ready,
    output logic signed [PSUM_W-1:0] o_psum,
    output logic                     o_psum_valid,
    output logic [2:0]               o_filter_idx,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int c_ROWS  = 3;
    localparam int c_ELEMS = 12;
    localparam int c_ROW_W = 20;   // 12 x 16-bit products cannot exceed 20 bits

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_W = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    // Pass configuration captured at start
    logic                    r_layer;
    logic [CNT_W-1:0]        r_num_win;
    logic [CNT_W-1:0]        r_win_cnt;

    // Issue tracking: a latched window with filters still to apply
    logic                    r_pending;
    logic [2:0]              r_filt;

    // Latched activation window, index 2 holds i_act_2
    logic [c_ROWS-1:0][95:0] r_act;
    logic [c_ROWS-1:0][95:0] w_wt;

    // Pipeline stage registers
    logic signed [15:0]        w_prod   [c_ROWS][c_ELEMS];
    logic signed [15:0]        r_prod   [c_ROWS][c_ELEMS];
    logic                      r_s1_v;
    logic [2:0]                r_s1_idx;
    logic signed [c_ROW_W-1:0] w_row_sum [c_ROWS];
    logic signed [c_ROW_W-1:0] r_row_sum [c_ROWS];
    logic                      r_s2_v;
    logic [2:0]                r_s2_idx;
    logic signed [PSUM_W-1:0]  w_total;

    logic                    w_hs;
    logic                    w_final_issue;
    logic                    w_all_accepted;

    // ------------------------------------------------------------------
    // Handshake and issue qualifiers
    // ------------------------------------------------------------------
    assign w_all_accepted = (r_win_cnt == r_num_win);
    // The current issue is the last one for its window: every conv1 issue,
    // or filter 7 in conv2.
    assign w_final_issue  = r_pending && (!r_layer || (r_filt == 3'd7));
    // Conv1 takes a window every cycle; conv2 only when the sweep is idle or
    // on its final filter so the next sweep follows with no gap.
    assign o_act_ready    = (r_state == S_RUN) && !w_all_accepted &&
                            (!r_layer || !r_pending || (r_filt == 3'd7));
    assign w_hs           = i_act_valid && o_act_ready;

    assign Filtr_2_count  = r_filt;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the pass sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_WAIT_W;
                end
            end
            S_WAIT_W: begin
                // An empty pass never needs weights; go straight to drain.
                if (r_num_win == '0) begin
                    w_state_nxt = S_DRAIN;
                end else if (weights_load_finish) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_all_accepted && (!r_pending || w_final_issue)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Stage-3 valid clears by itself next cycle, so only the
                // earlier stages must be empty for o_done to follow the
                // last result directly.
                if (!r_pending && !r_s1_v && !r_s2_v) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pass configuration, window counter and filter sweep control
    always_ff @(posedge clk) begin
        if (rst) begin
            r_layer   <= 1'b0;
            r_num_win <= '0;
            r_win_cnt <= '0;
            r_pending <= 1'b0;
            r_filt    <= 3'd0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_layer   <= layer_sel;
                r_num_win <= i_num_windows;
                r_win_cnt <= '0;
            end
            if (w_hs) begin
                r_win_cnt <= r_win_cnt + 1'b1;
            end
            if (w_hs) begin
                r_pending <= 1'b1;
            end else if (w_final_issue) begin
                r_pending <= 1'b0;
            end
            // Counter wraps 7 -> 0 so the next sweep always starts at filter 0.
            if (r_pending && r_layer) begin
                r_filt <= r_filt + 3'd1;
            end
        end
    end

    // Window capture on the handshake cycle
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_act <= {i_act_2, i_act_1, i_act_0};
        end
    end

    // Weight source: loader buses are sampled in the issue cycle
    always_comb begin
        w_wt = '0;
        if (r_layer) begin
            w_wt = {Filtr_2_2, Filtr_2_1, Filtr_2_0};
        end else begin
            w_wt = {Filtr_1_2, Filtr_1_1, Filtr_1_0};
        end
    end

    // Element-wise signed int8 products
    always_comb begin
        for (int r = 0; r < c_ROWS; r++) begin
            for (int k = 0; k < c_ELEMS; k++) begin
                w_prod[r][k] = 16'($signed(r_act[r][95-8*k -: 8])) *
                               16'($signed(w_wt[r][95-8*k -: 8]));
            end
        end
    end

    // Stage 1 data: register the 36 products of the current issue
    always_ff @(posedge clk) begin
        if (r_pending) begin
            for (int r = 0; r < c_ROWS; r++) begin
                for (int k = 0; k < c_ELEMS; k++) begin
                    r_prod[r][k] <= w_prod[r][k];
                end
            end
            r_s1_idx <= r_filt;
        end
    end

    // Row sums of the registered products
    always_comb begin
        for (int r = 0; r < c_ROWS; r++) begin
            w_row_sum[r] = '0;
            for (int k = 0; k < c_ELEMS; k++) begin
                w_row_sum[r] = w_row_sum[r] + c_ROW_W'(r_prod[r][k]);
            end
        end
    end

    // Stage 2 data: register the three row sums
    always_ff @(posedge clk) begin
        if (r_s1_v) begin
            for (int r = 0; r < c_ROWS; r++) begin
                r_row_sum[r] <= w_row_sum[r];
            end
            r_s2_idx <= r_s1_idx;
        end
    end

    // Final sum, sign-extended to the output width
    assign w_total = PSUM_W'(r_row_sum[0]) + PSUM_W'(r_row_sum[1]) +
                     PSUM_W'(r_row_sum[2]);

    // Pipeline valids and the output stage; o_psum holds between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v       <= 1'b0;
            r_s2_v       <= 1'b0;
            o_psum_valid <= 1'b0;
            o_psum       <= '0;
            o_filter_idx <= 3'd0;
        end else begin
            r_s1_v       <= r_pending;
            r_s2_v       <= r_s1_v;
            o_psum_valid <= r_s2_v;
            if (r_s2_v) begin
                o_psum       <= w_total;
                o_filter_idx <= r_s2_idx;
            end
        end
    end

endmodule
`default_nettype wire
